// File: rtl/bounded_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : bounded_down_counter
// Brief    : Programmable-bound down counter (UPPER -> LOWER). It has an
//            IDLE/RUN/DONE control FSM, a clamped synchronous load,
//            one-shot or wrapping mode, and a terminal-count flag.
// Options  : DOWNCNT_WRAP_COUNT_EN adds the 'wraps' output, which counts
//            terminal-count events.
// Revision : 1.0 - initial release
// ============================================================================
module bounded_down_counter #(
  parameter int WIDTH = 8,
  parameter int LOWER = 3,
  parameter int UPPER = 45
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
`ifdef DOWNCNT_WRAP_COUNT_EN
  ,
  output logic [WIDTH-1:0] wraps
`endif
);

  // Bounds as WIDTH-bit values, so compares and assignments match in width.
  localparam logic [WIDTH-1:0] LOWER_V = WIDTH'(LOWER);
  localparam logic [WIDTH-1:0] UPPER_V = WIDTH'(UPPER);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Refuse to elaborate when the bounds are inconsistent or UPPER does not fit in WIDTH.
  if ((WIDTH < 1) || (WIDTH > 32) || (LOWER < 0) || (LOWER >= UPPER) ||
      (longint'(UPPER) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_params
    $error("bounded_down_counter: illegal parameters (need 0 <= LOWER < UPPER <= 2^WIDTH-1)");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             start_accepted;
  logic             at_lower;

  // Force an arbitrary load value into the legal count range.
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    if (v < LOWER_V) return LOWER_V;
    if (v > UPPER_V) return UPPER_V;
    return v;
  endfunction

  assign at_lower = (count_q == LOWER_V);

  // Next state and next count. Priority is load, then start, then the enabled decrement.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    start_accepted = 1'b0;
    if (load) begin
      count_d = clamp(load_val);
      if (state_q == S_DONE) state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_d        = UPPER_V;
            state_d        = S_RUN;
            start_accepted = 1'b1;
          end
        end
        S_RUN: begin
          if (start) begin
            count_d        = UPPER_V;
            start_accepted = 1'b1;
          end else if (en) begin
            if (at_lower) begin
              // one_shot only matters here, at the terminal step.
              if (one_shot) state_d = S_DONE;
              else          count_d = UPPER_V;
            end else begin
              count_d = count_q - 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            count_d        = UPPER_V;
            state_d        = S_RUN;
            start_accepted = 1'b1;
          end
        end
        default: begin
          // An unreachable encoding falls back to a safe idle at the top of the range.
          state_d = S_IDLE;
          count_d = UPPER_V;
        end
      endcase
    end
  end

  // State and count registers. The asynchronous reset leaves the counter idle at UPPER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= UPPER_V;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (state_q == S_RUN) && en && at_lower;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);

`ifdef DOWNCNT_WRAP_COUNT_EN
  logic [WIDTH-1:0] wraps_q, wraps_d;

  // Count terminal-count events. An accepted start clears the count and wins over a coincident tc.
  always_comb begin
    wraps_d = wraps_q;
    if (start_accepted) wraps_d = '0;
    else if (tc)        wraps_d = wraps_q + 1'b1;
  end

  // Terminal-count event register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wraps_q <= '0;
    else     wraps_q <= wraps_d;
  end

  assign wraps = wraps_q;
`else
  // start_accepted only drives the wraps counter. Fold it here so it is not left unused.
  logic unused_start_accepted;
  assign unused_start_accepted = start_accepted;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bounded_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounded_down_counter
// Brief    : Directed, scoreboarded bench for bounded_down_counter with the
//            default parameters (WIDTH=8, LOWER=3, UPPER=45).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounded_down_counter;

  localparam int W  = 8;
  localparam int LO = 3;
  localparam int HI = 45;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, en = 1'b0, one_shot = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tc, busy, done;
`ifdef DOWNCNT_WRAP_COUNT_EN
  logic [W-1:0] wraps;
`endif

  bounded_down_counter #(.WIDTH(W), .LOWER(LO), .UPPER(HI)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .en       (en),
    .one_shot (one_shot),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
`ifdef DOWNCNT_WRAP_COUNT_EN
    ,
    .wraps    (wraps)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic [W-1:0] wraps;
  } exp_t;

  exp_t sb[$];

  int passed = 0;
  int total  = 0;

  // Reference model state
  int           m_state = M_IDLE;
  logic [W-1:0] m_count = W'(HI);
  logic [W-1:0] m_wraps = '0;
  int           tc_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_count = W'(HI);
    m_wraps = '0;
    sb.delete();
  endtask

  // Apply one cycle of stimulus: check tc, push the expected post-edge state, clock, pop and compare.
  task automatic cyc(input logic s, input logic e, input logic os,
                     input logic ld, input logic [W-1:0] lv);
    logic exp_tc;
    exp_t x;
    start = s; en = e; one_shot = os; load = ld; load_val = lv;
    #1;
    exp_tc = (m_state == M_RUN) && e && (m_count == W'(LO));
    chk("tc", {31'd0, tc}, {31'd0, exp_tc});
    if (exp_tc) tc_seen++;
    if (ld) begin
      m_count = (lv < W'(LO)) ? W'(LO) : (lv > W'(HI)) ? W'(HI) : lv;
      if (m_state == M_DONE) m_state = M_IDLE;
    end else if (s) begin
      m_count = W'(HI);
      m_state = M_RUN;
      m_wraps = '0;
    end else begin
      if (exp_tc) m_wraps = m_wraps + 1'b1;
      if (m_state == M_RUN && e) begin
        if (m_count == W'(LO)) begin
          if (os) m_state = M_DONE;
          else    m_count = W'(HI);
        end else begin
          m_count = m_count - 1'b1;
        end
      end
    end
    x.count = m_count;
    x.busy  = (m_state == M_RUN);
    x.done  = (m_state == M_DONE);
    x.wraps = m_wraps;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("count", {24'd0, count}, {24'd0, x.count});
    chk("busy",  {31'd0, busy},  {31'd0, x.busy});
    chk("done",  {31'd0, done},  {31'd0, x.done});
`ifdef DOWNCNT_WRAP_COUNT_EN
    chk("wraps", {24'd0, wraps}, {24'd0, x.wraps});
`endif
  endtask

  // Assert reset between edges and check the outputs before any clock edge arrives.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_count"}, {24'd0, count}, HI);
    chk({tag, "_busy"},  {31'd0, busy},  0);
    chk({tag, "_done"},  {31'd0, done},  0);
    chk({tag, "_tc"},    {31'd0, tc},    0);
`ifdef DOWNCNT_WRAP_COUNT_EN
    chk({tag, "_wraps"}, {24'd0, wraps}, 0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, {24'd0, count}, HI);
  endtask

  initial begin
    int n;
    start = 0; en = 1; one_shot = 0; load = 0; load_val = '0;

    // Reset, then idle with en high and no start
    async_reset("reset");
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    chk("idle_count", {24'd0, count}, HI);

    // One-shot run
    tc_seen = 0;
    cyc(1, 1, 1, 0, 0);
    chk("start_busy", {31'd0, busy}, 1);
    n = 0;
    while (m_state != M_DONE && n < 60) begin
      cyc(0, 1, 1, 0, 0);
      n++;
    end
    chk("oneshot_edges", n, HI - LO + 1);
    chk("oneshot_tc_pulses", tc_seen, 1);
    chk("done_count", {24'd0, count}, LO);
    chk("done_flag", {31'd0, done}, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
    chk("done_hold", {24'd0, count}, LO);

    // Continuous wrap: two full periods
    tc_seen = 0;
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 2 * (HI - LO + 1); i++) cyc(0, 1, 0, 0, 0);
    chk("wrap_tc_pulses", tc_seen, 2);
    chk("wrap_count", {24'd0, count}, HI);
`ifdef DOWNCNT_WRAP_COUNT_EN
    chk("wraps_two", {24'd0, wraps}, 2);
`endif

    // Enable gating at count 20
    cyc(1, 1, 0, 0, 0);
    n = 0;
    while (m_count != W'(20) && n < 60) begin
      cyc(0, 1, 0, 0, 0);
      n++;
    end
    chk("reach_20", {24'd0, count}, 20);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    chk("gated_hold", {24'd0, count}, 20);
    cyc(0, 1, 0, 0, 0);
    chk("gated_resume", {24'd0, count}, 19);

    // Load and clamp
    cyc(0, 1, 0, 1, 8'd100);
    chk("load_hi_clamp", {24'd0, count}, HI);
    cyc(0, 1, 0, 1, 8'd1);
    chk("load_lo_clamp", {24'd0, count}, LO);
    cyc(0, 1, 0, 1, 8'd10);
    chk("load_mid", {24'd0, count}, 10);
    cyc(1, 1, 0, 1, 8'd12);
    chk("load_over_start", {24'd0, count}, 12);
    chk("load_state_kept", {31'd0, busy}, 1);
    n = 0;
    while (m_state != M_DONE && n < 60) begin
      cyc(0, 1, 1, 0, 0);
      n++;
    end
    chk("done_again", {31'd0, done}, 1);
    cyc(0, 0, 0, 1, 8'd20);
    chk("load_done_idle", {31'd0, done | busy}, 0);
    chk("load_done_count", {24'd0, count}, 20);

    // Reset mid-operation and restart
    cyc(1, 1, 0, 0, 0);
    n = 0;
    while (m_count != W'(17) && n < 60) begin
      cyc(0, 1, 0, 0, 0);
      n++;
    end
    chk("reach_17", {24'd0, count}, 17);
    async_reset("midreset");
    cyc(1, 1, 0, 0, 0);
    n = 0;
    while (m_count != W'(30) && n < 60) begin
      cyc(0, 1, 0, 0, 0);
      n++;
    end
    cyc(1, 1, 0, 0, 0);
    chk("restart_count", {24'd0, count}, HI);
    chk("restart_busy", {31'd0, busy}, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
